spi_master_multi_cs: RTL

Parametrised SPI master, successor to the single-CS, fixed-mode, byte-wide master. Adds configurable word width and NUM_CS one-hot chip selects. SPI mode (CPOL/CPHA) and bit order are chosen per frame at runtime. Sits between a core-side valid/ready word interface and off-chip SPI peripherals; one frame carries 1..MAX_WORDS_PER_CS words under a single CS assertion.

---
 rtl/spi_master_multi_cs.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/spi_master_multi_cs.sv
// SPI master with runtime CPOL/CPHA and bit order, NUM_CS one-hot chip selects,
// and 1..MAX_WORDS_PER_CS words per chip-select frame behind a valid/ready word port.
module spi_master_multi_cs #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned NUM_CS            = 4,
  parameter int unsigned CLKS_PER_HALF_BIT = 4,
  parameter int unsigned MAX_WORDS_PER_CS  = 2,
  parameter int unsigned CS_INACTIVE_CLKS  = 10,
  parameter logic [1:0]  RESET_MODE        = 2'd3,
  localparam int unsigned CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int unsigned CNT_W = $clog2(MAX_WORDS_PER_CS + 1)
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic [CS_W-1:0]       i_CS_Sel,
  input  logic [1:0]            i_SPI_Mode,
  input  logic                  i_LSB_First,
  input  logic [CNT_W-1:0]      i_TX_Count,
  input  logic [DATA_WIDTH-1:0] i_TX_Word,
  input  logic                  i_TX_DV,
  output logic                  o_TX_Ready,
  output logic                  o_RX_DV,
  output logic [DATA_WIDTH-1:0] o_RX_Word,
  output logic [CNT_W-1:0]      o_RX_Count,
  output logic                  o_SPI_Clk,
  input  logic                  i_SPI_MISO,
  output logic                  o_SPI_MOSI,
  output logic [NUM_CS-1:0]     o_SPI_CS_n
);

  localparam int unsigned HB_W    = $clog2(CLKS_PER_HALF_BIT);
  localparam int unsigned EDGE_W  = $clog2(2 * DATA_WIDTH + 1);
  localparam int unsigned K_W     = EDGE_W - 1;
  localparam int unsigned BIT_W   = $clog2(DATA_WIDTH);
  localparam int unsigned INACT_W = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_WORD, CS_INACTIVE} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic [DATA_WIDTH-1:0] rx_sr_q;
  logic                  cpha_q;
  logic                  lsb_q;
  logic [CNT_W-1:0]      count_q;
  logic [HB_W-1:0]       clk_cnt_q;
  logic [EDGE_W-1:0]     edge_cnt_q;
  logic                  dv_done_q;
  logic [INACT_W-1:0]    inact_cnt_q;
  logic [NUM_CS-1:0]     cs_n_q;
  logic                  sclk_q;
  logic                  mosi_q;
  logic                  ready_q;
  logic                  rx_dv_q;
  logic [DATA_WIDTH-1:0] rx_word_q;
  logic [CNT_W-1:0]      rx_count_q;

  logic                  frame_ok_c;
  logic                  first_lsb_c;
  logic                  first_bit_c;
  logic                  leading_c;
  logic                  last_edge_c;
  logic [K_W-1:0]        bit_k_c;
  logic [BIT_W-1:0]      pos_k_c;
  logic [BIT_W-1:0]      pos_next_c;

  // Map the k-th transmitted bit to its index in the word for the chosen order.
  function automatic logic [BIT_W-1:0] bit_pos(input logic [K_W-1:0] k, input logic lsb);
    return lsb ? BIT_W'(k) : (BIT_W'(DATA_WIDTH - 1) - BIT_W'(k));
  endfunction

  always_comb begin
    frame_ok_c  = i_TX_DV && (i_TX_Count != '0) &&
                  (32'(i_TX_Count) <= 32'(MAX_WORDS_PER_CS)) &&
                  (32'(i_CS_Sel) < 32'(NUM_CS));
    first_lsb_c = (state_q == IDLE) ? i_LSB_First : lsb_q;
    first_bit_c = first_lsb_c ? i_TX_Word[0] : i_TX_Word[DATA_WIDTH-1];
    leading_c   = ~edge_cnt_q[0];
    last_edge_c = (edge_cnt_q == EDGE_W'(2 * DATA_WIDTH - 1));
    bit_k_c     = edge_cnt_q[EDGE_W-1:1];
    pos_k_c     = bit_pos(bit_k_c, lsb_q);
    pos_next_c  = bit_pos(bit_k_c + K_W'(1), lsb_q);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_sr_q     <= '0;
      cpha_q      <= RESET_MODE[0];
      lsb_q       <= 1'b0;
      count_q     <= '0;
      clk_cnt_q   <= '0;
      edge_cnt_q  <= '0;
      dv_done_q   <= 1'b0;
      inact_cnt_q <= '0;
      cs_n_q      <= '1;
      sclk_q      <= RESET_MODE[1];
      mosi_q      <= 1'b0;
      ready_q     <= 1'b1;
      rx_dv_q     <= 1'b0;
      rx_word_q   <= '0;
      rx_count_q  <= '0;
    end else begin
      rx_dv_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (frame_ok_c) begin
            tx_q       <= i_TX_Word;
            cpha_q     <= i_SPI_Mode[0];
            lsb_q      <= i_LSB_First;
            count_q    <= i_TX_Count;
            cs_n_q     <= ~(NUM_CS'(1) << i_CS_Sel);
            sclk_q     <= i_SPI_Mode[1];
            if (!i_SPI_Mode[0]) mosi_q <= first_bit_c;
            rx_count_q <= '0;
            ready_q    <= 1'b0;
            clk_cnt_q  <= '0;
            edge_cnt_q <= '0;
            dv_done_q  <= 1'b0;
            state_q    <= SHIFT;
          end
        end

        SHIFT: begin
          if (edge_cnt_q == EDGE_W'(2 * DATA_WIDTH)) begin
            // All edges done: pulse the word out, then decide the frame's fate.
            if (!dv_done_q) begin
              rx_dv_q   <= 1'b1;
              rx_word_q <= rx_sr_q;
              dv_done_q <= 1'b1;
            end else begin
              dv_done_q  <= 1'b0;
              rx_count_q <= rx_count_q + CNT_W'(1);
              if ((rx_count_q + CNT_W'(1)) < count_q) begin
                ready_q <= 1'b1;
                state_q <= WAIT_WORD;
              end else begin
                cs_n_q      <= '1;
                mosi_q      <= 1'b0;
                inact_cnt_q <= '0;
                state_q     <= CS_INACTIVE;
              end
            end
          end else if (clk_cnt_q == HB_W'(CLKS_PER_HALF_BIT - 1)) begin
            clk_cnt_q  <= '0;
            sclk_q     <= ~sclk_q;
            edge_cnt_q <= edge_cnt_q + EDGE_W'(1);
            // Sample on leading edges for CPHA=0, trailing for CPHA=1; drive on the others.
            if (leading_c ^ cpha_q) begin
              rx_sr_q[pos_k_c] <= i_SPI_MISO;
            end else if (cpha_q) begin
              mosi_q <= tx_q[pos_k_c];
            end else if (!last_edge_c) begin
              mosi_q <= tx_q[pos_next_c];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + HB_W'(1);
          end
        end

        WAIT_WORD: begin
          if (i_TX_DV) begin
            tx_q       <= i_TX_Word;
            if (!cpha_q) mosi_q <= first_bit_c;
            ready_q    <= 1'b0;
            clk_cnt_q  <= '0;
            edge_cnt_q <= '0;
            dv_done_q  <= 1'b0;
            state_q    <= SHIFT;
          end
        end

        CS_INACTIVE: begin
          if (inact_cnt_q == INACT_W'(CS_INACTIVE_CLKS - 1)) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            inact_cnt_q <= inact_cnt_q + INACT_W'(1);
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_TX_Ready = ready_q;
  assign o_RX_DV    = rx_dv_q;
  assign o_RX_Word  = rx_word_q;
  assign o_RX_Count = rx_count_q;
  assign o_SPI_Clk  = sclk_q;
  assign o_SPI_MOSI = mosi_q;
  assign o_SPI_CS_n = cs_n_q;

endmodule
